// File: rtl/n_term_pkg.sv
// Shared types for the north-terminal loopback matrix: per-output modes,
// the configuration FSM states, and the configuration word-count helper.
package n_term_pkg;

   typedef enum logic [1:0] {
      MODE_COMB = 2'b00,
      MODE_REG  = 2'b01,
      MODE_ZERO = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_COMMIT = 2'b10
   } state_e;

   function automatic int calc_nw(input int mb, input int cfg_w);
      return (mb + cfg_w - 1) / cfg_w;
   endfunction

endpackage

// File: rtl/n_term_out_cell.sv
// One output bit of the loopback matrix: selects routed input, registered
// copy, constant zero or a frozen copy according to its 2-bit mode.
module n_term_out_cell
   import n_term_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       route_i,
   input  logic [1:0] mode_i,
   output logic       out_o
);

   logic data_q;
   logic data_d;

   // ZERO keeps sampling so a later switch to REG/HOLD sees fresh data.
   assign data_d = (mode_i == MODE_HOLD) ? data_q : route_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= 1'b0;
      end else begin
         data_q <= data_d;
      end
   end

   always_comb begin
      out_o = data_q;
      case (mode_i)
         MODE_COMB: out_o = route_i;
         MODE_ZERO: out_o = 1'b0;
         default:   out_o = data_q;
      endcase
   end

endmodule

// File: rtl/n_term_loopback_matrix.sv
// North-terminal loopback switch matrix: index-reversed N->S return paths with
// per-output modes loaded word by word into a shadow and committed atomically.
module n_term_loopback_matrix
   import n_term_pkg::*;
#(
   parameter int N1_W  = 4,
   parameter int N2_W  = 8,
   parameter int N4_W  = 16,
   parameter int CFG_W = 8
) (
   input  logic             UserCLK,
   input  logic             resetn,
   input  logic [N1_W-1:0]  N1END,
   input  logic [N2_W-1:0]  N2MID,
   input  logic [N2_W-1:0]  N2END,
   input  logic [N4_W-1:0]  N4END,
   output logic [N1_W-1:0]  S1BEG,
   output logic [N2_W-1:0]  S2BEG,
   output logic [N2_W-1:0]  S2BEGb,
   output logic [N4_W-1:0]  S4BEG,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [CFG_W-1:0] cfg_data,
   output logic             cfg_ready,
   output logic             cfg_busy,
   output logic             cfg_done
);

   localparam int TOT  = N1_W + 2*N2_W + N4_W;
   localparam int MB   = 2*TOT;
   localparam int NW   = calc_nw(MB, CFG_W);
   localparam int SHW  = NW*CFG_W;
   localparam int WC_W = $clog2(NW+1);

   localparam int OFF_S2  = N1_W;
   localparam int OFF_S2B = N1_W + N2_W;
   localparam int OFF_S4  = N1_W + 2*N2_W;

   state_e          state_q, state_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic [SHW-1:0]  shadow_q, shadow_d;
   logic [MB-1:0]   active_q, active_d;
   logic            done_q, done_d;

   logic [TOT-1:0]  route_w;
   logic [TOT-1:0]  out_w;

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= '0;
         shadow_q <= '0;
         active_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      done_d    = 1'b0;
      cfg_ready = 1'b0;
      cfg_busy  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               wcnt_d  = '0;
            end
         end
         ST_LOAD: begin
            cfg_ready = 1'b1;
            cfg_busy  = 1'b1;
            if (cfg_valid) begin
               // Word 0 lands in the LSBs; constant slices keep the write decode simple.
               for (int w = 0; w < NW; w++) begin
                  if (wcnt_q == WC_W'(w)) shadow_d[w*CFG_W +: CFG_W] = cfg_data;
               end
               wcnt_d = wcnt_q + 1'b1;
               if (wcnt_q == WC_W'(NW-1)) state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            cfg_busy = 1'b1;
            active_d = shadow_q[MB-1:0];
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg_done = done_q;

   // Flat output order: S1BEG, S2BEG, S2BEGb, S4BEG, each LSB first.
   for (genvar i = 0; i < N1_W; i++) begin : g_r1
      assign route_w[i] = N1END[N1_W-1-i];
   end
   for (genvar i = 0; i < N2_W; i++) begin : g_r2
      assign route_w[OFF_S2+i]  = N2MID[N2_W-1-i];
      assign route_w[OFF_S2B+i] = N2END[N2_W-1-i];
   end
   for (genvar i = 0; i < N4_W; i++) begin : g_r4
      assign route_w[OFF_S4+i] = N4END[N4_W-1-i];
   end

   for (genvar k = 0; k < TOT; k++) begin : g_cell
      n_term_out_cell u_cell (
         .clk_i   (UserCLK),
         .rst_ni  (resetn),
         .route_i (route_w[k]),
         .mode_i  (active_q[2*k +: 2]),
         .out_o   (out_w[k])
      );
   end

   assign S1BEG  = out_w[N1_W-1:0];
   assign S2BEG  = out_w[OFF_S2 +: N2_W];
   assign S2BEGb = out_w[OFF_S2B +: N2_W];
   assign S4BEG  = out_w[OFF_S4 +: N4_W];

endmodule

// File: tb/tb_n_term_loopback_matrix.sv
// Directed bench for n_term_loopback_matrix: routing table in COMB and REG
// modes, ZERO/HOLD behaviour, stalled/noisy loads and reset during a load.
module tb_n_term_loopback_matrix;

   logic        UserCLK;
   logic        resetn;
   logic [3:0]  N1END;
   logic [7:0]  N2MID, N2END;
   logic [15:0] N4END;
   logic [3:0]  S1BEG;
   logic [7:0]  S2BEG, S2BEGb;
   logic [15:0] S4BEG;
   logic        cfg_start, cfg_valid, cfg_ready, cfg_busy, cfg_done;
   logic [7:0]  cfg_data;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int done_base, acc_base;
   logic [7:0] wbuf [9];

   typedef struct {
      logic [3:0]  n1;
      logic [7:0]  n2m;
      logic [7:0]  n2e;
      logic [15:0] n4;
      logic [3:0]  s1;
      logic [7:0]  s2;
      logic [7:0]  s2b;
      logic [15:0] s4;
   } vec_t;

   vec_t vt [4];
   vec_t prev;

   n_term_loopback_matrix dut (
      .UserCLK   (UserCLK),
      .resetn    (resetn),
      .N1END     (N1END),
      .N2MID     (N2MID),
      .N2END     (N2END),
      .N4END     (N4END),
      .S1BEG     (S1BEG),
      .S2BEG     (S2BEG),
      .S2BEGb    (S2BEGb),
      .S4BEG     (S4BEG),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   always @(negedge UserCLK) begin
      if (cfg_done) done_cnt++;
      if (cfg_valid && cfg_ready) acc_cnt++;
   end

   task automatic tick();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      N1END = v.n1;
      N2MID = v.n2m;
      N2END = v.n2e;
      N4END = v.n4;
   endtask

   task automatic chk_out(input string nm, input vec_t v);
      chk({nm, ".S1BEG"},  32'(S1BEG),  32'(v.s1));
      chk({nm, ".S2BEG"},  32'(S2BEG),  32'(v.s2));
      chk({nm, ".S2BEGb"}, 32'(S2BEGb), 32'(v.s2b));
      chk({nm, ".S4BEG"},  32'(S4BEG),  32'(v.s4));
   endtask

   task automatic feed_words(input int n, input int gap, input bit noise);
      int guard;
      for (int j = 0; j < n; j++) begin
         if (gap > 0 && j > 0) begin
            cfg_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
               if (noise && j == 4 && g == 1) cfg_start = 1'b1;
               tick();
               cfg_start = 1'b0;
            end
         end
         cfg_valid = 1'b1;
         cfg_data  = wbuf[j];
         guard = 0;
         while (!cfg_ready && guard < 50) begin
            tick();
            guard++;
         end
         chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic load_cfg(input int gap, input bit noise);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      feed_words(9, gap, noise);
      chk("commit_ctrl", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b100);
      tick();
      chk("done_ctrl", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b001);
      tick();
      chk("idle_ctrl", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b000);
   endtask

   task automatic fill(input logic [7:0] w);
      for (int j = 0; j < 9; j++) wbuf[j] = w;
   endtask

   initial begin
      vt[0] = '{4'h1, 8'h00, 8'h00, 16'h8001, 4'h8, 8'h00, 8'h00, 16'h8001};
      vt[1] = '{4'h3, 8'h01, 8'h80, 16'h00FF, 4'hC, 8'h80, 8'h01, 16'hFF00};
      vt[2] = '{4'hA, 8'h0F, 8'hC3, 16'h1234, 4'h5, 8'hF0, 8'hC3, 16'h2C48};
      vt[3] = '{4'hF, 8'hA5, 8'h12, 16'hFFFF, 4'hF, 8'hA5, 8'h48, 16'hFFFF};

      resetn = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data = 8'h00;
      N1END = '0; N2MID = '0; N2END = '0; N4END = '0;
      repeat (3) @(posedge UserCLK);
      #1;
      chk("rst_ctrl", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b000);
      resetn = 1'b1;
      tick();

      // Power-up configuration is the plain combinational loopback.
      for (int i = 0; i < 4; i++) begin
         drive(vt[i]);
         #1;
         chk_out($sformatf("comb%0d", i), vt[i]);
      end

      // All REG: outputs lag the routed inputs by one cycle.
      fill(8'h55);
      load_cfg(0, 1'b0);
      N1END = '0; N2MID = '0; N2END = '0; N4END = '0;
      tick();
      prev = '{4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 8'h00, 8'h00, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         drive(vt[i]);
         #1;
         chk_out($sformatf("reg_same%0d", i), prev);
         tick();
         chk_out($sformatf("reg_next%0d", i), vt[i]);
         prev = vt[i];
      end

      // All ZERO: outputs stay low whatever the inputs do.
      fill(8'hAA);
      load_cfg(0, 1'b0);
      N1END = 4'hF; N2MID = 8'hFF; N2END = 8'hFF; N4END = 16'hFFFF;
      #1;
      chk("zero_hi", 32'({S1BEG, S2BEG, S2BEGb, S4BEG}), 32'h0);
      tick();
      chk("zero_hi_reg", 32'({S1BEG, S2BEG, S2BEGb, S4BEG}), 32'h0);
      N1END = '0; N2MID = '0; N2END = '0; N4END = '0;
      tick();
      chk("zero_lo", 32'({S1BEG, S2BEG, S2BEGb, S4BEG}), 32'h0);

      // Back to REG: S4BEG follows the reversed N4END after one cycle.
      fill(8'h55);
      load_cfg(0, 1'b0);
      N4END = 16'h1234;
      #1;
      chk("zreg_s4_same", 32'(S4BEG), 32'h0000);
      tick();
      chk("zreg_s4_next", 32'(S4BEG), 32'h2C48);

      // REG -> HOLD freezes the last sampled value; HOLD -> REG resumes.
      N1END = 4'hF;
      tick();
      fill(8'hFF);
      load_cfg(0, 1'b0);
      N1END = 4'h0;
      tick();
      tick();
      chk("hold_s1", 32'(S1BEG), 32'hF);
      chk("hold_s4", 32'(S4BEG), 32'h2C48);
      fill(8'h55);
      load_cfg(0, 1'b0);
      chk("unhold_s1", 32'(S1BEG), 32'h0);

      // Stalled source with a stray cfg_start; mixed per-group modes.
      N1END = '0; N2MID = '0; N2END = '0; N4END = 16'h8000;
      tick();
      wbuf = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      done_base = done_cnt;
      acc_base = acc_cnt;
      load_cfg(3, 1'b1);
      chk("bp_words", 32'(acc_cnt - acc_base), 32'd9);
      chk("bp_done", 32'(done_cnt - done_base), 32'd1);
      N1END = 4'h1; N2MID = 8'hFF; N2END = 8'h80; N4END = 16'h0000;
      #1;
      chk_out("mix_same", '{4'h0, 8'h00, 8'h00, 16'h0, 4'h8, 8'h00, 8'h00, 16'h0001});
      tick();
      chk_out("mix_next", '{4'h0, 8'h00, 8'h00, 16'h0, 4'h8, 8'h00, 8'h01, 16'h0001});

      // Reset in the middle of a load discards it and restores COMB.
      done_base = done_cnt;
      fill(8'h55);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      feed_words(5, 0, 1'b0);
      resetn = 1'b0;
      #1;
      chk("abort_ctrl", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b000);
      N1END = 4'h3; N2MID = 8'h01;
      #1;
      chk("abort_s1", 32'(S1BEG), 32'hC);
      chk("abort_s2", 32'(S2BEG), 32'h80);
      tick();
      resetn = 1'b1;
      tick();
      tick();
      chk("abort_ctrl2", 32'({cfg_busy, cfg_ready, cfg_done}), 32'b000);
      chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
      load_cfg(0, 1'b0);
      chk("reload_done", 32'(done_cnt - done_base), 32'd1);
      N2MID = 8'h0F;
      #1;
      chk("reload_s2_same", 32'(S2BEG), 32'h80);
      tick();
      chk("reload_s2_next", 32'(S2BEG), 32'hF0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/n_term_loopback_matrix.md
Name: n_term_loopback_matrix

Overview:
- Parametrised north-terminal loopback switch matrix. Returns every incoming north wire (N1END, N2MID, N2END, N4END) to its southbound counterpart with index reversal, as the fixed terminal tiles do.
- Adds a per-output mode: combinational, registered, tied-low, or hold.
- Mode configuration is loaded through a word-streaming valid/ready port into a shadow register, then committed atomically.
- Sits at the north edge of RAM/IO columns in the fabric.

Parameters:
- N1_W, 4, number of single-hop wires
- N2_W, 8, number of double-hop wires per group (MID and END)
- N4_W, 16, number of quad-hop wires
- CFG_W, 8, configuration word width
- Derived, not overridable: TOT = N1_W + 2*N2_W + N4_W (36); MB = 2*TOT (72); NW = ceil(MB/CFG_W) (9).

Ports:
- UserCLK  in  1  fabric user clock
- resetn  in  1  asynchronous active-low reset
- N1END  in  N1_W  single-hop inputs
- N2MID  in  N2_W  double-hop mid inputs
- N2END  in  N2_W  double-hop end inputs
- N4END  in  N4_W  quad-hop inputs
- S1BEG  out  N1_W  single-hop outputs
- S2BEG  out  N2_W  double-hop outputs (from N2MID)
- S2BEGb  out  N2_W  double-hop outputs (from N2END)
- S4BEG  out  N4_W  quad-hop outputs
- cfg_start  in  1  pulse; begins a configuration load
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  CFG_W  configuration word
- cfg_ready  out  1  block accepts a word this cycle
- cfg_busy  out  1  load or commit in progress
- cfg_done  out  1  one-cycle pulse when the new configuration becomes active

Behaviour:
- Routing, before mode is applied:
  - S1BEG[i] = N1END[N1_W-1-i]
  - S2BEG[i] = N2MID[N2_W-1-i]
  - S2BEGb[i] = N2END[N2_W-1-i]
  - S4BEG[i] = N4END[N4_W-1-i]
- Flat output index k (0..TOT-1) orders S1BEG, then S2BEG, S2BEGb, S4BEG, each LSB first. mode[k] = active[2k+1:2k].
- Mode encoding:
  - 00 COMB: output = routed input, zero latency.
  - 01 REG: output = data_q[k]; data_q[k] samples the routed input every UserCLK edge (1-cycle latency).
  - 10 ZERO: output = 0; data_q[k] still samples.
  - 11 HOLD: output = data_q[k]; data_q[k] is not updated.
- Reset (resetn low, asynchronous):
  - active = all 00, so power-up behaviour equals the legacy fixed loopback (outputs follow inputs combinationally).
  - data_q = 0, shadow = 0, FSM = IDLE.
  - cfg_ready = 0, cfg_busy = 0, cfg_done = 0.
- FSM states IDLE, LOAD, COMMIT:
  - IDLE: cfg_ready = 0. cfg_start → LOAD, clear word counter wcnt.
  - LOAD: cfg_ready = 1, cfg_busy = 1. On cfg_valid & cfg_ready, write shadow[wcnt*CFG_W +: CFG_W] = cfg_data and increment wcnt. Acceptance of word NW-1 → COMMIT.
  - COMMIT (one cycle): cfg_ready = 0, cfg_busy = 1. active ← shadow[MB-1:0]; bits of the last word at or above MB are discarded. cfg_done = 1 in the following cycle, then → IDLE.
- Configuration takes effect atomically: new modes apply from the cycle after COMMIT. data_q is not cleared on commit.
  - HOLD→REG: sampling resumes at the next edge.
  - REG→HOLD: freezes the value sampled at the commit edge.
- cfg_start during LOAD or COMMIT is ignored; the load in progress continues.
- cfg_valid in IDLE is ignored and no word is consumed.
- The source may stall indefinitely in LOAD. The block waits with no timeout.
- resetn asserted mid-LOAD or mid-COMMIT aborts the load and restores the reset configuration. No partial configuration becomes active.
- Word 0 carries the configuration LSBs.

Decomposition:
- Shared package n_term_pkg holds:
  - mode enum (MODE_COMB = 2'b00, MODE_REG = 2'b01, MODE_ZERO = 2'b10, MODE_HOLD = 2'b11)
  - FSM state enum
  - function computing NW from MB and CFG_W
- One natural sub-module, n_term_out_cell: a single-bit routed-input, mode, data_q, output cell, instantiated TOT times.
- Config FSM and shadow stay in the top level.

Test Plan:
- Reset, no config: drive N1END = 4'b0001, N4END = 16'h8001 → S1BEG = 4'b1000 and S4BEG = 16'h8001 in the same cycle. cfg_ready = 0, cfg_busy = 0.
- Load 9 words of 8'h55 (all outputs REG): cfg_done pulses exactly 1 cycle after COMMIT. Set N2MID = 8'h01 → S2BEG = 8'h80 one cycle later, not the same cycle.
- All ZERO (9 × 8'hAA), then toggle every input → all outputs remain 0. Then all REG (9 × 8'h55) → S4BEG follows the reversed N4END after 1 cycle.
- HOLD: with REG active, N1END = 4'hF, then commit 9 × 8'hFF → S1BEG stays 4'hF while N1END changes to 4'h0.
- Backpressure and noise: cfg_valid gaps of 3 cycles between words, plus cfg_start re-pulsed mid-load → exactly 9 accepted words, one cfg_done, configuration matches the data sent.
- Assert resetn after 5 of 9 words → all modes COMB, FSM IDLE, no cfg_done. A following full load succeeds.
